// File: rtl/mem_data_ram_ws_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_ram_ws_if
// Description : Request/response bundle between the CPU data port (master)
//               and the wait-state data RAM (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_data_ram_ws_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr_bus;
    logic [31:0] write_data_bus;
    logic [31:0] read_data_bus;
    logic        ready;
    logic        fault;
    logic        busy;

    modport master (
        output req, we, size, unsigned_ld, addr_bus, write_data_bus,
        input  read_data_bus, ready, fault, busy
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr_bus, write_data_bus,
        output read_data_bus, ready, fault, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_data_ram_ws.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_ram_ws
// Description : Byte-addressable 32-bit data RAM with lane-steered stores,
//               sign/zero-extended sub-word loads, a programmable wait-state
//               counter behind a req/ready handshake and a fault response for
//               misaligned or out-of-range accesses. ADDR_WIDTH must be <= 29.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_ram_ws #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    mem_data_ram_ws_if.slave   bus
);

    localparam int         DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic [1:0]              r_lane;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic                    r_illegal;

    logic [31:0]             mem [DEPTH];

    logic [31:0]             w_offset;
    logic                    w_illegal;
    logic [31:0]             w_word;
    logic [31:0]             w_shifted;
    logic [31:0]             w_load;
    logic [3:0]              w_be;
    logic [31:0]             w_wlanes;
    logic                    w_commit;

    // Legality of the request currently on the bus. BASE_ADDR is word-aligned,
    // so the low offset bits equal the low address bits.
    always_comb begin
        w_offset  = bus.addr_bus - BASE_ADDR;
        w_illegal = 1'b0;
        if (bus.size == 2'b11)
            w_illegal = 1'b1;
        if ((bus.size == 2'b01) && w_offset[0])
            w_illegal = 1'b1;
        if ((bus.size == 2'b10) && (w_offset[1:0] != 2'b00))
            w_illegal = 1'b1;
        // Offsets past the array (including addresses below BASE_ADDR,
        // which wrap to huge offsets) are rejected.
        if (|w_offset[31:ADDR_WIDTH+2])
            w_illegal = 1'b1;
    end

    // Load path: pick the lane(s) of the addressed word and extend.
    always_comb begin
        w_word    = mem[r_idx];
        w_shifted = w_word >> {r_lane, 3'b000};
        case (r_size)
            2'b00:   w_load = {{24{~r_uns & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // Store path: replicate right-justified data onto every lane and enable
    // only the lanes the access covers.
    always_comb begin
        case (r_size)
            2'b00: begin
                w_be     = 4'b0001 << r_lane;
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = 4'b0011 << {r_lane[1], 1'b0};
                w_wlanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
        endcase
    end

    // Access edge: last wait cycle of a legal request; reset suppresses it.
    assign w_commit = (r_state == ST_WAIT) && !r_illegal &&
                      (r_cnt == 4'd0) && !reset;

    // Array write port; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (w_commit && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    mem[r_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    // Handshake FSM with registered ready/fault/busy/read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_cnt             <= 4'd0;
            r_we              <= 1'b0;
            r_size            <= 2'b00;
            r_uns             <= 1'b0;
            r_lane            <= 2'b00;
            r_idx             <= '0;
            r_wdata           <= 32'd0;
            r_illegal         <= 1'b0;
            bus.ready         <= 1'b0;
            bus.fault         <= 1'b0;
            bus.busy          <= 1'b0;
            bus.read_data_bus <= 32'd0;
        end else begin
            bus.ready <= 1'b0;
            bus.fault <= 1'b0;
            case (r_state)
                // The edge that ends DONE may accept the next request, which
                // gives back-to-back throughput of 2+WAIT_STATES cycles.
                ST_IDLE, ST_DONE: begin
                    if (bus.req) begin
                        r_state   <= ST_WAIT;
                        r_cnt     <= C_WAIT_INIT;
                        r_we      <= bus.we;
                        r_size    <= bus.size;
                        r_uns     <= bus.unsigned_ld;
                        r_lane    <= w_offset[1:0];
                        r_idx     <= w_offset[ADDR_WIDTH+1:2];
                        r_wdata   <= bus.write_data_bus;
                        r_illegal <= w_illegal;
                        bus.busy  <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_illegal) begin
                        // Rejected requests finish after one cycle, no access.
                        r_state   <= ST_DONE;
                        bus.ready <= 1'b1;
                        bus.fault <= 1'b1;
                        if (!r_we)
                            bus.read_data_bus <= 32'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_state   <= ST_DONE;
                        bus.ready <= 1'b1;
                        if (!r_we)
                            bus.read_data_bus <= w_load;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_data_ram_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_data_ram_ws
// Description : Self-checking bench for mem_data_ram_ws. Four instances with
//               WAIT_STATES = 0, 1, 3, 5 share one stimulus bus; req is routed
//               only to the selected instance. Expected values come from a
//               byte-array memory model and the documented timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_data_ram_ws;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          AW   = 4;
    localparam int          NB   = 4 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr_bus;
    logic [31:0] wdata;
    int          sel;

    logic [3:0]  rdy_v;
    logic [3:0]  flt_v;
    logic [3:0]  busy_v;
    logic [31:0] rd_v [4];

    int checks = 0;
    int errors = 0;

    logic [7:0]  mbytes [4][NB];
    logic [31:0] mrd [4];

    always #5 clk = ~clk;

    mem_data_ram_ws_if bus_if [4] ();

    for (genvar i = 0; i < 4; i++) begin : g_dut
        assign bus_if[i].req            = req && (sel == i);
        assign bus_if[i].we             = we;
        assign bus_if[i].size           = size;
        assign bus_if[i].unsigned_ld    = unsigned_ld;
        assign bus_if[i].addr_bus       = addr_bus;
        assign bus_if[i].write_data_bus = wdata;
        assign rdy_v[i]                 = bus_if[i].ready;
        assign flt_v[i]                 = bus_if[i].fault;
        assign busy_v[i]                = bus_if[i].busy;
        assign rd_v[i]                  = bus_if[i].read_data_bus;

        mem_data_ram_ws #(
            .ADDR_WIDTH  (AW),
            .WAIT_STATES ((i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 5),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_if[i])
        );
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int ws_of(input int s);
        case (s)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (sz == 2'd3) return 1'b0;
        if (sz == 2'd1 && a[0]) return 1'b0;
        if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b0;
        return off < 32'(NB);
    endfunction

    function automatic logic [31:0] m_load(input int s, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
        int          off;
        int          n;
        logic [31:0] v;
        off = int'(a - BASE);
        n   = 1 << sz;
        v   = 32'd0;
        for (int b = 0; b < n; b++)
            v = v | (32'(mbytes[s][off+b]) << (8*b));
        if (!u && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic m_store(input int s, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        int off;
        int n;
        off = int'(a - BASE);
        n   = 1 << sz;
        for (int b = 0; b < n; b++)
            mbytes[s][off+b] = wd[8*b +: 8];
    endtask

    // One request on instance s; returns latency (edges from acceptance to
    // the edge after which ready is seen, -1 on timeout) and the outputs.
    task automatic do_access(input int s, input logic w, input logic [1:0] sz,
                             input logic u, input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic flt, output logic [31:0] rd,
                             output logic bok);
        @(negedge clk);
        sel = s; we = w; size = sz; unsigned_ld = u; addr_bus = a; wdata = wd;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        bok = busy_v[s];
        lat = -1; flt = 1'b0; rd = 32'd0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (!busy_v[s]) bok = 1'b0;
            if (rdy_v[s]) begin
                lat = n; flt = flt_v[s]; rd = rd_v[s];
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
        addr_bus = BASE; wdata = 32'd0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (rdy_v[s] !== 1'b0 || flt_v[s] !== 1'b0 || busy_v[s] !== 1'b0 || rd_v[s] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got ready=%b fault=%b busy=%b rd=%h, need 0/0/0/0",
                         s, rdy_v[s], flt_v[s], busy_v[s], rd_v[s]);
            end
            mrd[s] = 32'd0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill;
        int lat; logic flt; logic [31:0] rd; logic bok; logic [31:0] v;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < NB/4; w++) begin
                v = $urandom;
                do_access(s, 1'b1, 2'd2, 1'b0, BASE + 32'(4*w), v, lat, flt, rd, bok);
                m_store(s, 2'd2, BASE + 32'(4*w), v);
                checks++;
                if (lat !== 1 + ws_of(s) || flt !== 1'b0) begin
                    errors++;
                    $display("FAIL fill inst%0d w%0d: got lat=%0d fault=%b, need lat=%0d fault=0",
                             s, w, lat, flt, 1 + ws_of(s));
                end
            end
        end
    endtask

    task automatic test_word;
        int lat; logic flt; logic [31:0] rd; logic bok;
        do_access(1, 1'b1, 2'd2, 1'b0, BASE + 8, 32'hDEADBEEF, lat, flt, rd, bok);
        m_store(1, 2'd2, BASE + 8, 32'hDEADBEEF);
        checks++;
        if (lat !== 2 || flt !== 1'b0 || bok !== 1'b1) begin
            errors++;
            $display("FAIL word_store: got lat=%0d fault=%b busy_ok=%b, need 2/0/1", lat, flt, bok);
        end
        do_access(1, 1'b0, 2'd2, 1'b0, BASE + 8, 32'd0, lat, flt, rd, bok);
        mrd[1] = 32'hDEADBEEF;
        checks++;
        if (lat !== 2 || flt !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_load: got lat=%0d fault=%b rd=%h, need 2/0/deadbeef", lat, flt, rd);
        end
    endtask

    task automatic test_lanes;
        int lat; logic flt; logic [31:0] rd; logic bok;
        do_access(1, 1'b1, 2'd0, 1'b0, BASE + 9, 32'hFFFF_FF80, lat, flt, rd, bok);
        m_store(1, 2'd0, BASE + 9, 32'hFFFF_FF80);
        do_access(1, 1'b0, 2'd0, 1'b0, BASE + 9, 32'd0, lat, flt, rd, bok);
        checks++;
        if (rd !== 32'hFFFF_FF80 || flt !== 1'b0) begin
            errors++;
            $display("FAIL byte_signed: got %h fault=%b, need ffffff80 fault=0", rd, flt);
        end
        do_access(1, 1'b0, 2'd0, 1'b1, BASE + 9, 32'd0, lat, flt, rd, bok);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++;
            $display("FAIL byte_unsigned: got %h, need 00000080", rd);
        end
        do_access(1, 1'b0, 2'd2, 1'b0, BASE + 8, 32'd0, lat, flt, rd, bok);
        mrd[1] = 32'hDEAD80EF;
        checks++;
        if (rd !== 32'hDEAD80EF) begin
            errors++;
            $display("FAIL byte_lane_word: got %h, need dead80ef", rd);
        end
    endtask

    task automatic test_half;
        int lat; logic flt; logic [31:0] rd; logic bok; logic [31:0] exp_w;
        do_access(1, 1'b1, 2'd1, 1'b0, BASE + 2, 32'h0000_8001, lat, flt, rd, bok);
        m_store(1, 2'd1, BASE + 2, 32'h0000_8001);
        do_access(1, 1'b0, 2'd1, 1'b0, BASE + 2, 32'd0, lat, flt, rd, bok);
        checks++;
        if (rd !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL half_signed: got %h, need ffff8001", rd);
        end
        exp_w = m_load(1, 2'd2, 1'b0, BASE);
        do_access(1, 1'b0, 2'd2, 1'b0, BASE, 32'd0, lat, flt, rd, bok);
        mrd[1] = exp_w;
        checks++;
        if (rd !== exp_w || rd[31:16] !== 16'h8001) begin
            errors++;
            $display("FAIL half_lanes_word: got %h, need %h", rd, exp_w);
        end
    endtask

    task automatic test_faults;
        int lat; logic flt; logic [31:0] rd; logic bok; logic [31:0] pre; logic [31:0] exp_rd;
        logic        f_we [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  f_sz [7] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1};
        logic [31:0] f_ad [7] = '{BASE + 2, BASE + 1, BASE, BASE + 32'(NB), BASE - 4,
                                  BASE + 32'(NB), BASE + 5};
        for (int i = 0; i < 7; i++) begin
            // Leave a non-zero load result behind before each fault.
            pre = m_load(2, 2'd2, 1'b0, BASE + 32'(4*i));
            do_access(2, 1'b0, 2'd2, 1'b0, BASE + 32'(4*i), 32'd0, lat, flt, rd, bok);
            exp_rd = f_we[i] ? pre : 32'd0;
            do_access(2, f_we[i], f_sz[i], 1'b0, f_ad[i], $urandom, lat, flt, rd, bok);
            mrd[2] = exp_rd;
            checks++;
            if (lat !== 1 || flt !== 1'b1 || rd !== exp_rd || bok !== 1'b1) begin
                errors++;
                $display("FAIL fault_case%0d: got lat=%0d fault=%b rd=%h busy_ok=%b, need 1/1/%h/1",
                         i, lat, flt, rd, bok, exp_rd);
            end
        end
        for (int w = 0; w < NB/4; w++) begin
            pre = m_load(2, 2'd2, 1'b0, BASE + 32'(4*w));
            do_access(2, 1'b0, 2'd2, 1'b0, BASE + 32'(4*w), 32'd0, lat, flt, rd, bok);
            mrd[2] = pre;
            checks++;
            if (rd !== pre || flt !== 1'b0) begin
                errors++;
                $display("FAIL fault_readback w%0d: got %h, need %h", w, rd, pre);
            end
        end
    endtask

    task automatic test_random;
        int lat; logic flt; logic [31:0] rd; logic bok;
        logic w; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] wd;
        int off; logic legal; int exp_lat; logic [31:0] exp_rd;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 25; i++) begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                u  = 1'($urandom_range(0, 1));
                wd = $urandom;
                off = int'($urandom_range(0, NB + 7));
                if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                    off = off & ~((1 << sz) - 1);
                a = BASE + 32'(off);
                if ($urandom_range(0, 9) == 0)
                    a = BASE - 32'($urandom_range(1, 8));
                legal   = m_legal(sz, a);
                exp_lat = legal ? 1 + ws_of(s) : 1;
                if (w)          exp_rd = mrd[s];
                else if (legal) exp_rd = m_load(s, sz, u, a);
                else            exp_rd = 32'd0;
                do_access(s, w, sz, u, a, wd, lat, flt, rd, bok);
                if (legal && w) m_store(s, sz, a, wd);
                mrd[s] = exp_rd;
                checks++;
                if (lat !== exp_lat || flt !== !legal || rd !== exp_rd || bok !== 1'b1) begin
                    errors++;
                    $display("FAIL random inst%0d op%0d we=%b sz=%0d a=%h: got lat=%0d fault=%b rd=%h busy_ok=%b, need %0d/%b/%h/1",
                             s, i, w, sz, a, lat, flt, rd, bok, exp_lat, !legal, exp_rd);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int idx [3] = '{0, 1, 3};
        for (int k = 0; k < 3; k++) begin
            int s; int ws; int per; int last; int npulse; int pulse_at [3];
            logic bok; logic [31:0] exp_rd; logic ok;
            s = idx[k]; ws = ws_of(s); per = 2 + ws; last = 5 + 3*ws;
            npulse = 0; bok = 1'b1; pulse_at = '{-1, -1, -1};
            exp_rd = m_load(s, 2'd2, 1'b0, BASE + 16);
            @(negedge clk);
            sel = s; we = 1'b0; size = 2'd2; unsigned_ld = 1'b0; addr_bus = BASE + 16;
            req = 1'b1;
            for (int e = 0; e <= last; e++) begin
                @(posedge clk); #1;
                if (!busy_v[s]) bok = 1'b0;
                if (rdy_v[s]) begin
                    if (npulse < 3) pulse_at[npulse] = e;
                    npulse++;
                end
            end
            req = 1'b0;
            ok = (npulse == 3);
            for (int m = 0; m < 3; m++)
                if (pulse_at[m] != 1 + ws + m*per) ok = 1'b0;
            checks++;
            if (!ok || !bok) begin
                errors++;
                $display("FAIL back_to_back ws%0d: got pulses=%0d at %0d,%0d,%0d busy_ok=%b, need 3 at %0d,%0d,%0d busy_ok=1",
                         ws, npulse, pulse_at[0], pulse_at[1], pulse_at[2], bok,
                         1 + ws, 1 + ws + per, 1 + ws + 2*per);
            end
            checks++;
            if (rd_v[s] !== exp_rd || flt_v[s] !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back_data ws%0d: got %h fault=%b, need %h fault=0",
                         ws, rd_v[s], flt_v[s], exp_rd);
            end
            mrd[s] = exp_rd;
            @(posedge clk); #1;
            checks++;
            if (busy_v[s] !== 1'b0 || rdy_v[s] !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back_drain ws%0d: got busy=%b ready=%b, need 0/0",
                         ws, busy_v[s], rdy_v[s]);
            end
        end
    endtask

    task automatic test_req_toggle;
        int lat; logic flt; logic [31:0] rd; logic bok;
        int s; int ws; int npulse; int first; logic busy_ok; logic [31:0] v;
        s = 3; ws = ws_of(s); npulse = 0; first = -1; busy_ok = 1'b1; v = $urandom;
        @(negedge clk);
        sel = s; we = 1'b1; size = 2'd2; unsigned_ld = 1'b0; addr_bus = BASE + 20; wdata = v;
        req = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= ws + 8; e++) begin
            if (e <= ws + 1) begin
                req      = 1'($urandom_range(0, 1));
                we       = 1'($urandom_range(0, 1));
                size     = 2'($urandom_range(0, 3));
                addr_bus = BASE + 32'($urandom_range(0, NB - 1));
                wdata    = $urandom;
            end else begin
                req = 1'b0;
            end
            @(posedge clk); #1;
            if (rdy_v[s]) begin
                if (first < 0) first = e;
                npulse++;
            end
            if (busy_v[s] !== (e <= ws + 1)) busy_ok = 1'b0;
        end
        req = 1'b0;
        m_store(s, 2'd2, BASE + 20, v);
        checks++;
        if (npulse != 1 || first != ws + 1 || !busy_ok) begin
            errors++;
            $display("FAIL req_toggle: got pulses=%0d first=%0d busy_ok=%b, need 1 at %0d busy_ok=1",
                     npulse, first, busy_ok, ws + 1);
        end
        do_access(s, 1'b0, 2'd2, 1'b0, BASE + 20, 32'd0, lat, flt, rd, bok);
        mrd[s] = v;
        checks++;
        if (rd !== v || lat !== 1 + ws) begin
            errors++;
            $display("FAIL req_toggle_data: got %h lat=%0d, need %h lat=%0d", rd, lat, v, 1 + ws);
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic flt; logic [31:0] rd; logic bok; logic [31:0] old; logic quiet;
        old = m_load(1, 2'd2, 1'b0, BASE + 12);
        @(negedge clk);
        sel = 1; we = 1'b1; size = 2'd2; unsigned_ld = 1'b0; addr_bus = BASE + 12;
        wdata = 32'h1234_5678; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rdy_v[1] !== 1'b0 || flt_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || rd_v[1] !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort_outputs: got ready=%b fault=%b busy=%b rd=%h, need 0/0/0/0",
                     rdy_v[1], flt_v[1], busy_v[1], rd_v[1]);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) mrd[s] = 32'd0;
        quiet = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy_v !== 4'b0000 || busy_v !== 4'b0000) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_abort_quiet: got stray ready/busy, need none");
        end
        do_access(1, 1'b0, 2'd2, 1'b0, BASE + 12, 32'd0, lat, flt, rd, bok);
        mrd[1] = old;
        checks++;
        if (rd !== old || lat !== 2) begin
            errors++;
            $display("FAIL reset_abort_data: got %h lat=%0d, need %h lat=2", rd, lat, old);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word();
        test_lanes();
        test_half();
        test_faults();
        test_random();
        test_back_to_back();
        test_req_toggle();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
